mem_arbiter: RTL and testbench

Two-client memory arbiter between the L1 caches and the single shared 128-bit-line memory port. The instruction cache (read-only) and the data cache (read/write) each issue line-granularity requests. The arbiter serialises them onto one memory channel and returns each response with a one-cycle ready pulse to the requester. It sits directly on the cache memory interface, so each cache sees a memory that behaves exactly like the bare memory, only with longer latency.

---
 rtl/mem_if_pkg.sv | 13 +
 rtl/rr_arb2.sv | 12 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: line/address widths, arbiter state encoding and client IDs
// shared between the caches and the memory arbiter.
package mem_if_pkg;
    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam logic CL_I = 1'b0;
    localparam logic CL_D = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-request round-robin grant; on a tie the client
// not granted last wins (last_d_i=0 means I was last, so D wins).
module rr_arb2 (
    input  logic req_i_i,
    input  logic req_d_i,
    input  logic last_d_i,
    output logic any_o,
    output logic gnt_d_o
);
    assign any_o   = req_i_i | req_d_i;
    assign gnt_d_o = req_d_i & (~req_i_i | ~last_d_i);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache line requests onto one memory
// port, returning each response with a registered one-cycle ready pulse.
module mem_arbiter
    import mem_if_pkg::*;
(
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [LINE_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [LINE_W-1:0] dc_mem_wdata,
    output logic [LINE_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic                cl_q, cl_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
    logic                ic_rdy_q, ic_rdy_d, dc_rdy_q, dc_rdy_d;
    logic                any_req, gnt_d;

    rr_arb2 u_arb (
        .req_i_i (ic_mem_read),
        .req_d_i (dc_mem_read | dc_mem_write),
        .last_d_i(last_d_q),
        .any_o   (any_req),
        .gnt_d_o (gnt_d)
    );

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        cl_d       = cl_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        ic_rdy_d   = 1'b0;
        dc_rdy_d   = 1'b0;
        case (state_q)
            S_IDLE: if (any_req) begin
                state_d  = S_BUSY;
                last_d_d = gnt_d;
                cl_d     = gnt_d ? CL_D : CL_I;
                // read+write from the D-cache resolves to a write
                wr_d     = gnt_d & dc_mem_write;
                rd_d     = gnt_d ? ~dc_mem_write : 1'b1;
                addr_d   = gnt_d ? dc_mem_addr : ic_mem_addr;
                wdata_d  = gnt_d ? dc_mem_wdata : '0;
            end
            S_BUSY: if (mem_ready) begin
                state_d    = S_DONE;
                rd_d       = 1'b0;
                wr_d       = 1'b0;
                ic_rdata_d = (cl_q == CL_I) ? mem_rdata : ic_rdata_q;
                dc_rdata_d = (cl_q == CL_D) ? mem_rdata : dc_rdata_q;
                ic_rdy_d   = (cl_q == CL_I);
                dc_rdy_d   = (cl_q == CL_D);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q    <= S_IDLE;
            last_d_q   <= 1'b0;
            cl_q       <= CL_I;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            ic_rdy_q   <= 1'b0;
            dc_rdy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            cl_q       <= cl_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
            ic_rdy_q   <= ic_rdy_d;
            dc_rdy_q   <= dc_rdy_d;
        end
    end

    assign mem_read     = rd_q;
    assign mem_write    = wr_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign ic_mem_rdata = ic_rdata_q;
    assign dc_mem_rdata = dc_rdata_q;
    assign ic_mem_ready = ic_rdy_q;
    assign dc_mem_ready = dc_rdy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for the two-client memory arbiter.
module tb_mem_arbiter;
    import mem_if_pkg::*;

    localparam logic [LINE_W-1:0] IC_LINE = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [LINE_W-1:0] DC_LINE = 128'hCAFEF00D_11112222_33334444_55556666;
    localparam logic [LINE_W-1:0] WDATA   = 128'hDEADBEEF_00000000_12345678_DEADBEEF;

    logic              clk = 1'b0;
    logic              proc_reset = 1'b1;
    logic              ic_mem_read = 1'b0;
    logic [ADDR_W-1:0] ic_mem_addr = '0;
    logic [LINE_W-1:0] ic_mem_rdata;
    logic              ic_mem_ready;
    logic              dc_mem_read = 1'b0;
    logic              dc_mem_write = 1'b0;
    logic [ADDR_W-1:0] dc_mem_addr = '0;
    logic [LINE_W-1:0] dc_mem_wdata = '0;
    logic [LINE_W-1:0] dc_mem_rdata;
    logic              dc_mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
        .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
        .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
        .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
        .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({mem_read, mem_write, ic_mem_ready, dc_mem_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, ic_mem_ready, dc_mem_ready});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || ic_mem_rdata !== '0 || dc_mem_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h ic_rdata=%h dc_rdata=%h expected all 0", mem_addr, mem_wdata, ic_mem_rdata, dc_mem_rdata);
        end
        tick;
        proc_reset = 1'b0;
        tick;
    endtask

    task automatic test_ic_read;
        ic_mem_read = 1'b1;
        ic_mem_addr = 28'h0000010;
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL ic_req: mem_read=%b mem_write=%b expected 1 0", mem_read, mem_write);
        end
        checks++;
        if (mem_addr !== 28'h0000010 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL ic_addr: addr=%h wdata=%h expected 0000010 0", mem_addr, mem_wdata);
        end
        tick;
        tick;
        mem_ready = 1'b1;
        mem_rdata = IC_LINE;
        tick;
        mem_ready = 1'b0;
        mem_rdata = '0;
        checks++;
        if (ic_mem_ready !== 1'b1 || dc_mem_ready !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL ic_done: ic_rdy=%b dc_rdy=%b mem_read=%b expected 1 0 0", ic_mem_ready, dc_mem_ready, mem_read);
        end
        checks++;
        if (ic_mem_rdata !== IC_LINE) begin
            errors++;
            $display("FAIL ic_rdata: got %h expected %h", ic_mem_rdata, IC_LINE);
        end
        tick;
        ic_mem_read = 1'b0;
        checks++;
        if (ic_mem_ready !== 1'b0 || ic_mem_rdata !== IC_LINE) begin
            errors++;
            $display("FAIL ic_pulse: ic_rdy=%b rdata=%h expected 0 %h", ic_mem_ready, ic_mem_rdata, IC_LINE);
        end
        tick;
    endtask

    task automatic test_dc_write;
        dc_mem_write = 1'b1;
        dc_mem_addr  = 28'h00000A0;
        dc_mem_wdata = WDATA;
        tick;
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h00000A0) begin
            errors++;
            $display("FAIL dc_wr_req: wr=%b rd=%b addr=%h expected 1 0 00000a0", mem_write, mem_read, mem_addr);
        end
        checks++;
        if (mem_wdata !== WDATA) begin
            errors++;
            $display("FAIL dc_wdata: got %h expected %h", mem_wdata, WDATA);
        end
        tick;
        mem_ready = 1'b1;
        mem_rdata = DC_LINE;
        tick;
        mem_ready = 1'b0;
        mem_rdata = '0;
        checks++;
        if (dc_mem_ready !== 1'b1 || ic_mem_ready !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL dc_done: dc_rdy=%b ic_rdy=%b mem_write=%b expected 1 0 0", dc_mem_ready, ic_mem_ready, mem_write);
        end
        checks++;
        if (dc_mem_rdata !== DC_LINE || ic_mem_rdata !== IC_LINE) begin
            errors++;
            $display("FAIL dc_rdata: dc=%h ic=%h expected %h %h", dc_mem_rdata, ic_mem_rdata, DC_LINE, IC_LINE);
        end
        tick;
        dc_mem_write = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        proc_reset = 1'b1;
        tick;
        proc_reset = 1'b0;
        ic_mem_read  = 1'b1;
        ic_mem_addr  = 28'h0000100;
        dc_mem_write = 1'b1;
        dc_mem_addr  = 28'h0000200;
        dc_mem_wdata = WDATA;
        tick;
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 28'h0000200) begin
            errors++;
            $display("FAIL tie1_grant: wr=%b addr=%h expected 1 0000200", mem_write, mem_addr);
        end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        checks++;
        if (dc_mem_ready !== 1'b1 || ic_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL tie1_done: dc_rdy=%b ic_rdy=%b expected 1 0", dc_mem_ready, ic_mem_ready);
        end
        tick;
        dc_mem_write = 1'b0;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL dead_cycle: rd=%b wr=%b expected 0 0", mem_read, mem_write);
        end
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000100 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL tie2_grant: rd=%b addr=%h wdata=%h expected 1 0000100 0", mem_read, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        checks++;
        if (ic_mem_ready !== 1'b1 || dc_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL tie2_done: ic_rdy=%b dc_rdy=%b expected 1 0", ic_mem_ready, dc_mem_ready);
        end
        tick;
        ic_mem_read = 1'b0;
        tick;
        ic_mem_read = 1'b1;
        dc_mem_read = 1'b1;
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000200) begin
            errors++;
            $display("FAIL tie3_grant: rd=%b addr=%h expected 1 0000200", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        checks++;
        if (dc_mem_ready !== 1'b1 || ic_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL tie3_done: dc_rdy=%b ic_rdy=%b expected 1 0", dc_mem_ready, ic_mem_ready);
        end
        tick;
        ic_mem_read = 1'b0;
        dc_mem_read = 1'b0;
        tick;
    endtask

    task automatic test_addr_change;
        ic_mem_read = 1'b1;
        ic_mem_addr = 28'h0000001;
        tick;
        ic_mem_addr = 28'h0000002;
        tick;
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000001) begin
            errors++;
            $display("FAIL addr_hold: rd=%b addr=%h expected 1 0000001", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = DC_LINE;
        tick;
        mem_ready = 1'b0;
        mem_rdata = '0;
        checks++;
        if (ic_mem_ready !== 1'b1 || ic_mem_rdata !== DC_LINE) begin
            errors++;
            $display("FAIL addr_done: ic_rdy=%b rdata=%h expected 1 %h", ic_mem_ready, ic_mem_rdata, DC_LINE);
        end
        tick;
        ic_mem_read = 1'b0;
        tick;
    endtask

    task automatic test_stale_request;
        ic_mem_read = 1'b1;
        ic_mem_addr = 28'h0000030;
        tick;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        checks++;
        if (ic_mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL stale_done: ic_rdy=%b expected 1", ic_mem_ready);
        end
        tick;
        ic_mem_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (mem_read !== 1'b0 || ic_mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL stale_regrant[%0d]: rd=%b ic_rdy=%b expected 0 0", i, mem_read, ic_mem_ready);
            end
        end
    endtask

    task automatic test_reset_mid;
        dc_mem_read = 1'b1;
        dc_mem_addr = 28'h0000300;
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000300) begin
            errors++;
            $display("FAIL rst_pre: rd=%b addr=%h expected 1 0000300", mem_read, mem_addr);
        end
        proc_reset = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, ic_mem_ready, dc_mem_ready} !== 4'b0000 || ic_mem_rdata !== '0 || dc_mem_rdata !== '0) begin
            errors++;
            $display("FAIL rst_async: ctrl=%b ic_rdata=%h dc_rdata=%h expected 0000 0 0", {mem_read, mem_write, ic_mem_ready, dc_mem_ready}, ic_mem_rdata, dc_mem_rdata);
        end
        tick;
        proc_reset = 1'b0;
        dc_mem_read = 1'b0;
        tick;
        ic_mem_read = 1'b1;
        ic_mem_addr = 28'h0000400;
        dc_mem_read = 1'b1;
        dc_mem_addr = 28'h0000500;
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000500) begin
            errors++;
            $display("FAIL rst_regrant: rd=%b addr=%h expected 1 0000500", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = IC_LINE;
        tick;
        mem_ready = 1'b0;
        checks++;
        if (dc_mem_ready !== 1'b1 || dc_mem_rdata !== IC_LINE || ic_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_done: dc_rdy=%b dc_rdata=%h ic_rdy=%b expected 1 %h 0", dc_mem_ready, dc_mem_rdata, ic_mem_ready, IC_LINE);
        end
        tick;
        ic_mem_read = 1'b0;
        dc_mem_read = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_ic_read;
        test_dc_write;
        test_back_to_back;
        test_addr_change;
        test_stale_request;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
